stego_seq_ctrl: RTL and testbench

Top-level sequencer for the encrypted-LSB-steganography datapath. It serially loads a 128-bit key and a 128-bit plaintext over two 1-bit lanes each and presents them to the AES cipher core. It waits a fixed pipeline latency, captures the ciphertext, then embeds it one bit per cover byte into an 8-bit cover stream with valid/ready handshakes on both sides. It sits between the pad/Wishbone front end and the `aescipher`/embedding datapath.

---
 rtl/stego_pkg.sv | 23 ++
 rtl/stego_embed_stage.sv | 35 +++
 rtl/stego_seq_ctrl.sv | 110 +++++++++++
 tb/tb_stego_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stego_pkg.sv
// Shared state encoding and widths for the stego block sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stego_pkg;

  localparam int BLK_W     = 128;
  localparam int LANE_BITS = 64;
  localparam int BYTE_W    = 8;

  // Fixed encodings so older code that decodes the raw state bits keeps working.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_CIPHER = 2'd2;
  localparam logic [1:0] ST_EMBED  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    CIPHER = ST_CIPHER,
    EMBED  = ST_EMBED
  } state_t;

endpackage

// File: rtl/stego_embed_stage.sv
// Single-entry output register that replaces each cover byte's LSB with one payload bit.
// Latency: 1 cycle from cover accept to stego byte valid.
// Backpressure: cov_ready follows st_ready combinationally, so a full register still accepts when it drains the same cycle.
module stego_embed_stage
  import stego_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pay_bit,
  input  logic              cov_valid,
  input  logic [BYTE_W-1:0] cov_data,
  output logic              cov_ready,
  output logic              st_valid,
  output logic [BYTE_W-1:0] st_data,
  input  logic              st_ready
);

  // Accept a cover byte only while enabled and the register is empty or emptying now.
  assign cov_ready = en && (!st_valid || st_ready);

  // Load a new stego byte on accept; otherwise drop valid once the byte is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= 1'b0;
      st_data  <= '0;
    end else if (cov_valid && cov_ready) begin
      st_valid <= 1'b1;
      st_data  <= (cov_data & ~BYTE_W'(1)) | BYTE_W'(pay_bit);
    end else if (st_ready) begin
      st_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stego_seq_ctrl.sv
// Block sequencer: serially loads key/plaintext, waits out the cipher core, then embeds the ciphertext in cover LSBs.
// Latency: 1 + 64 + AES_LAT + BLK_W + 1 cycles from start to done without stalls; cover-to-stego is 1 cycle.
// Backpressure: cov_ready drops while an undelivered stego byte is held and st_ready is low; stalls never lose data.
module stego_seq_ctrl
  import stego_pkg::*;
#(
  parameter int AES_LAT = 12,
  parameter int BLK_W   = stego_pkg::BLK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        key_in,
  input  logic [1:0]        data_in,
  output logic [BLK_W-1:0]  aes_key,
  output logic [BLK_W-1:0]  aes_din,
  input  logic [BLK_W-1:0]  aes_dout,
  input  logic              cov_valid,
  input  logic [BYTE_W-1:0] cov_data,
  output logic              cov_ready,
  output logic              st_valid,
  output logic [BYTE_W-1:0] st_data,
  input  logic              st_ready,
  output logic              load_done,
  output logic              busy,
  output logic              done
);

  // Each lane fills one half of the block, so a load takes HALF cycles.
  localparam int HALF  = BLK_W / 2;
  localparam int IDX_W = $clog2(BLK_W + 1);

  state_t           state;
  logic [7:0]       cnt;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] payload;
  logic             en;

  // idx reaching BLK_W means every payload bit has been handed to the output register.
  assign en        = (state == EMBED) && (idx < IDX_W'(BLK_W));
  assign busy      = (state != IDLE);
  assign load_done = (state == LOAD) && (cnt == 8'(HALF - 1));
  assign done      = (state == EMBED) && st_valid && st_ready && (idx == IDX_W'(BLK_W));

  // Sequencer: lane shift-in, cipher wait, payload capture and bit walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      payload <= '0;
      aes_key <= '0;
      aes_din <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          // Shift in at the top of each half so the first bit (LSB) lands at bit 0 / bit HALF.
          aes_key <= {key_in[1], aes_key[BLK_W-1:HALF+1], key_in[0], aes_key[HALF-1:1]};
          aes_din <= {data_in[1], aes_din[BLK_W-1:HALF+1], data_in[0], aes_din[HALF-1:1]};
          if (cnt == 8'(HALF - 1)) begin
            state <= CIPHER;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CIPHER: begin
          if (cnt == 8'(AES_LAT - 1)) begin
            payload <= aes_dout;
            idx     <= '0;
            state   <= EMBED;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EMBED: begin
          // payload[0] always holds the next bit to embed.
          if (cov_valid && cov_ready) begin
            payload <= payload >> 1;
            idx     <= idx + IDX_W'(1);
          end
          if (done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stego_embed_stage u_embed (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pay_bit   (payload[0]),
    .cov_valid (cov_valid),
    .cov_data  (cov_data),
    .cov_ready (cov_ready),
    .st_valid  (st_valid),
    .st_data   (st_data),
    .st_ready  (st_ready)
  );

endmodule

// File: tb/tb_stego_seq_ctrl.sv
// Directed bench for stego_seq_ctrl: handshake vector table plus hand-written block sequences.
module tb_stego_seq_ctrl;

  localparam int AES_LAT = 12;
  // Edges after the start edge until the done edge; counting the start cycle as 1 this is cycle 206.
  localparam int DONE_EDGE = 1 + 64 + AES_LAT + 128;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   key_in;
  logic [1:0]   data_in;
  logic [127:0] aes_key;
  logic [127:0] aes_din;
  logic [127:0] aes_dout;
  logic         cov_valid;
  logic [7:0]   cov_data;
  logic         cov_ready;
  logic         st_valid;
  logic [7:0]   st_data;
  logic         st_ready;
  logic         load_done;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       cv;
    logic [7:0] cd;
    logic       sr;
    logic       ecr;
    logic       esv;
    logic [7:0] esd;
  } vec_t;

  vec_t tbl[11];

  logic [127:0] ka, da, pa, kb, db, pb, kc, dc, pc, kd, dd, pd;
  logic [7:0]   exp_q[$];

  stego_seq_ctrl #(.AES_LAT(AES_LAT), .BLK_W(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .data_in   (data_in),
    .aes_key   (aes_key),
    .aes_din   (aes_din),
    .aes_dout  (aes_dout),
    .cov_valid (cov_valid),
    .cov_data  (cov_data),
    .cov_ready (cov_ready),
    .st_valid  (st_valid),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .load_done (load_done),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_aes_key"},   aes_key, 128'(0));
    chk({tag, "_aes_din"},   aes_din, 128'(0));
    chk({tag, "_cov_ready"}, 128'(cov_ready), 128'(0));
    chk({tag, "_st_valid"},  128'(st_valid), 128'(0));
    chk({tag, "_st_data"},   128'(st_data), 128'(0));
    chk({tag, "_load_done"}, 128'(load_done), 128'(0));
    chk({tag, "_busy"},      128'(busy), 128'(0));
    chk({tag, "_done"},      128'(done), 128'(0));
  endtask

  // Runs start, LOAD and CIPHER; returns at the negedge inside the first EMBED cycle.
  task automatic load_cipher(input logic [127:0] k, input logic [127:0] d,
                             input logic [127:0] p, input logic poke);
    int ld;
    @(negedge clk);
    aes_dout = p;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ld    = 0;
    chk("busy_load", 128'(busy), 128'(1));
    for (int c = 0; c < 64; c++) begin
      key_in  = {k[64+c], k[c]};
      data_in = {d[64+c], d[c]};
      #1;
      if (load_done) ld++;
      if (c == 63) chk("load_done_last", 128'(load_done), 128'(1));
      @(negedge clk);
    end
    key_in  = 2'b00;
    data_in = 2'b00;
    chk("load_done_count", 128'(ld), 128'(1));
    chk("aes_key_loaded", aes_key, k);
    chk("aes_din_loaded", aes_din, d);
    for (int c = 0; c < AES_LAT; c++) begin
      start = poke && (c == 4);
      #1;
      if (c == AES_LAT - 1) begin
        chk("cov_ready_cipher", 128'(cov_ready), 128'(0));
        chk("busy_cipher", 128'(busy), 128'(1));
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Full block with a constant cover byte and no backpressure.
  task automatic run_full(input logic [127:0] k, input logic [127:0] d, input logic [127:0] p,
                          input logic [7:0] cd, input logic poke);
    int  e, acc, n;
    logic got_done, rd_chk;
    load_cipher(k, d, p, poke);
    e        = 1 + 64 + AES_LAT;
    acc      = 0;
    n        = 0;
    got_done = 1'b0;
    rd_chk   = 1'b0;
    cov_valid = 1'b1;
    st_ready  = 1'b1;
    for (int i = 0; i < 300 && !got_done; i++) begin
      cov_data = cd;
      start    = poke && (i == 20);
      #1;
      if (acc == 128 && !rd_chk) begin
        chk("cov_ready_after_last", 128'(cov_ready), 128'(0));
        rd_chk = 1'b1;
      end
      if (poke && i == 21) chk("busy_start_in_embed", 128'(busy), 128'(1));
      if (cov_valid && cov_ready) acc++;
      if (st_valid && st_ready) begin
        chk($sformatf("st_data_%0d", n), 128'(st_data), 128'({cd[7:1], p[n]}));
        n++;
        if (done) begin
          chk("done_edge", 128'(e), 128'(DONE_EDGE));
          got_done = 1'b1;
        end
      end
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    if (!got_done) chk("done_timeout", 128'(0), 128'(1));
    chk("bytes_out", 128'(n), 128'(128));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_cov_ready", 128'(cov_ready), 128'(0));
      chk("post_st_valid", 128'(st_valid), 128'(0));
      chk("post_busy", 128'(busy), 128'(0));
      @(negedge clk);
    end
    cov_valid = 1'b0;
    chk("aes_key_held", aes_key, k);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, dlv, cyc;
    logic fin, prev_stall;
    logic [7:0] prev_dat, e8;

    ka = 128'h000102030405060708090A0B0C0D0E0F;
    da = {128{1'b1}};
    pa = {16{8'hA5}};
    kb = 128'hFEDCBA9876543210_0123456789ABCDEF;
    db = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    pb = {16{8'h69}};
    kc = 128'h55555555_AAAAAAAA_33333333_CCCCCCCC;
    dc = 128'h1;
    pc = {16{8'h0F}};
    kd = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    dd = 128'h3243F6A8885A308D313198A2E0370734;
    pd = 128'h3925841D02DC09FBDC118597196A0B32;

    // Handshake vectors from the first EMBED cycle with payload 0x69 per byte
    // (bits LSB first: 1,0,0,1,0). Fields: cov_valid, cov_data, st_ready,
    // expected cov_ready, st_valid, st_data (st_data checked only when valid).
    tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h82, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[3]  = '{1'b0, 8'h82, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[4]  = '{1'b1, 8'h82, 1'b1, 1'b1, 1'b1, 8'h41};
    tbl[5]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h82};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h32};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'hF1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00};

    rst       = 1'b1;
    start     = 1'b0;
    key_in    = 2'b00;
    data_in   = 2'b00;
    aes_dout  = '0;
    cov_valid = 1'b0;
    cov_data  = 8'h00;
    st_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Block A: pattern key, all-ones data, 0xA5 payload, start poked in CIPHER and EMBED.
    run_full(ka, da, pa, 8'hFE, 1'b1);

    // Block B: table-driven handshake corners, then random stalls with a scoreboard.
    load_cipher(kb, db, pb, 1'b0);
    for (int i = 0; i < 11; i++) begin
      cov_valid = tbl[i].cv;
      cov_data  = tbl[i].cd;
      st_ready  = tbl[i].sr;
      #1;
      chk($sformatf("tbl%0d_cov_ready", i), 128'(cov_ready), 128'(tbl[i].ecr));
      chk($sformatf("tbl%0d_st_valid", i), 128'(st_valid), 128'(tbl[i].esv));
      if (tbl[i].esv) chk($sformatf("tbl%0d_st_data", i), 128'(st_data), 128'(tbl[i].esd));
      chk($sformatf("tbl%0d_done", i), 128'(done), 128'(0));
      @(negedge clk);
    end
    acc        = 5;
    dlv        = 5;
    fin        = 1'b0;
    prev_stall = 1'b0;
    prev_dat   = 8'h00;
    exp_q.delete();
    for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
      cov_valid = ($urandom_range(0, 3) != 0);
      cov_data  = 8'($urandom_range(0, 255));
      st_ready  = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        chk("stall_valid", 128'(st_valid), 128'(1));
        chk("stall_data", 128'(st_data), 128'(prev_dat));
      end
      if (acc >= 128) chk("rand_cov_ready_full", 128'(cov_ready), 128'(0));
      if (cov_valid && cov_ready && acc < 128) begin
        exp_q.push_back({cov_data[7:1], pb[acc]});
        acc++;
      end
      if (st_valid && st_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_byte", 128'(st_data), 128'(0));
        end else begin
          e8 = exp_q.pop_front();
          chk($sformatf("rand_byte_%0d", dlv), 128'(st_data), 128'(e8));
        end
        dlv++;
        chk($sformatf("rand_done_%0d", dlv), 128'(done), 128'(dlv == 128));
        if (done) fin = 1'b1;
      end
      prev_stall = st_valid && !st_ready;
      prev_dat   = st_data;
      @(negedge clk);
    end
    if (!fin) chk("rand_done_timeout", 128'(0), 128'(1));
    chk("rand_bytes", 128'(dlv), 128'(128));
    #1;
    chk("rand_busy_after", 128'(busy), 128'(0));
    cov_valid = 1'b0;
    st_ready  = 1'b1;

    // Block C: abort with rst while the 50th byte is in flight.
    load_cipher(kc, dc, pc, 1'b0);
    cov_valid = 1'b1;
    cov_data  = 8'h3C;
    acc       = 0;
    for (int i = 0; i < 200 && acc < 50; i++) begin
      #1;
      if (cov_valid && cov_ready) acc++;
      @(negedge clk);
    end
    #1;
    chk("abort_accepts", 128'(acc), 128'(50));
    chk("abort_inflight", 128'(st_valid), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("abort");
    @(negedge clk);
    rst       = 1'b0;
    cov_valid = 1'b0;

    // Block D: a fresh start after the abort must complete a full block.
    run_full(kd, dd, pd, 8'h5A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
